// File: rtl/fp_adder_multi_compare_stage.sv
// fp_adder_multi_compare_stage
// Two-stage valid/ready exponent compare stage for LANES floating-point adder
// lanes. S1 registers operand A (accumulator or bias, chosen per transaction)
// and operand B. S2 compares the exponents and registers the larger exponent,
// the exponent-difference magnitude and the swapped mantissas.
// Optional feature macro: FP_CMP_DIFF_SAT_EN. When it is defined,
// exponent_diff is clamped to MANTISA_WIDTH.
module fp_adder_multi_compare_stage #(
    parameter int LANES          = 2,
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISA_WIDTH  = 24
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  bias_mode,
    input  logic [LANES*EXPONENT_WIDTH-1:0]       exponent_acc,
    input  logic [LANES*EXPONENT_WIDTH-1:0]       exponent_bias,
    input  logic [LANES*EXPONENT_WIDTH-1:0]       exponent_b,
    input  logic [LANES*MANTISA_WIDTH-1:0]        mantissa_acc,
    input  logic [LANES*MANTISA_WIDTH-1:0]        mantissa_bias,
    input  logic [LANES*MANTISA_WIDTH-1:0]        mantissa_b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*(EXPONENT_WIDTH+1)-1:0]   exponent_diff,
    output logic [LANES*EXPONENT_WIDTH-1:0]       exponent_big,
    output logic [LANES*MANTISA_WIDTH-1:0]        mantissa_big,
    output logic [LANES*MANTISA_WIDTH-1:0]        mantissa_small,
    output logic [LANES-1:0]                      a_is_big
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISA_WIDTH;
    localparam int DW = EXPONENT_WIDTH + 1;

    // S1 (select) registers
    logic                r_s1_valid;
    logic [LANES*EW-1:0] r_s1_exp_a;
    logic [LANES*EW-1:0] r_s1_exp_b;
    logic [LANES*MW-1:0] r_s1_man_a;
    logic [LANES*MW-1:0] r_s1_man_b;

    // S2 (compare) output registers
    logic                r_out_valid;
    logic [LANES*DW-1:0] r_exponent_diff;
    logic [LANES*EW-1:0] r_exponent_big;
    logic [LANES*MW-1:0] r_mantissa_big;
    logic [LANES*MW-1:0] r_mantissa_small;
    logic [LANES-1:0]    r_a_is_big;

    // Combinational compare results feeding the output registers
    logic                w_s2_adv;
    logic                w_accept;
    logic [LANES*DW-1:0] w_diff;
    logic [LANES*EW-1:0] w_exp_big;
    logic [LANES*MW-1:0] w_man_big;
    logic [LANES*MW-1:0] w_man_small;
    logic [LANES-1:0]    w_a_big;

    // S1 moves forward whenever the output register is empty or being drained.
    assign w_s2_adv = r_s1_valid & (~r_out_valid | out_ready);
    // Handshakes are masked during rst so nothing is exchanged in that cycle.
    assign in_ready = ~rst & (~r_s1_valid | w_s2_adv);
    assign w_accept = in_valid & in_ready;

    // Per-lane exponent compare and operand swap.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DW-1:0] w_ext_a;
        logic signed [DW-1:0] w_ext_b;
        logic signed [DW-1:0] w_d;
        logic [DW-1:0]        w_mag;

        // One extra bit keeps the full -(2^EW-1)..(2^EW-1) difference exact.
        assign w_ext_a = {r_s1_exp_a[gi*EW+EW-1], r_s1_exp_a[gi*EW +: EW]};
        assign w_ext_b = {r_s1_exp_b[gi*EW+EW-1], r_s1_exp_b[gi*EW +: EW]};
        assign w_d     = w_ext_b - w_ext_a;

        // A wins only on a strictly larger exponent; ties pick B as big.
        assign w_a_big[gi] = w_d[DW-1];
        assign w_mag       = w_a_big[gi] ? DW'(w_ext_a - w_ext_b) : DW'(w_d);

`ifdef FP_CMP_DIFF_SAT_EN
        // Shifts past the mantissa width are all equivalent for the aligner.
        assign w_diff[gi*DW +: DW] = (32'(w_mag) > MW) ? DW'(MW) : w_mag;
`else
        assign w_diff[gi*DW +: DW] = w_mag;
`endif

        assign w_exp_big[gi*EW +: EW]   = w_a_big[gi] ? r_s1_exp_a[gi*EW +: EW]
                                                      : r_s1_exp_b[gi*EW +: EW];
        assign w_man_big[gi*MW +: MW]   = w_a_big[gi] ? r_s1_man_a[gi*MW +: MW]
                                                      : r_s1_man_b[gi*MW +: MW];
        assign w_man_small[gi*MW +: MW] = w_a_big[gi] ? r_s1_man_b[gi*MW +: MW]
                                                      : r_s1_man_a[gi*MW +: MW];
    end

    // S1 occupancy: set on accept, cleared when its content moves to S2.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S1 payload: operand A is picked once here, by the beat's own bias_mode.
    always_ff @(posedge clk) begin
        // NOTE: the payload is not reset; r_s1_valid qualifies it, and the
        // output registers that are visible do reset to zero.
        if (w_accept) begin
            r_s1_exp_a <= bias_mode ? exponent_bias : exponent_acc;
            r_s1_man_a <= bias_mode ? mantissa_bias : mantissa_acc;
            r_s1_exp_b <= exponent_b;
            r_s1_man_b <= mantissa_b;
        end
    end

    // S2 output registers: load on advance, hold while stalled, drain on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid      <= 1'b0;
            r_exponent_diff  <= '0;
            r_exponent_big   <= '0;
            r_mantissa_big   <= '0;
            r_mantissa_small <= '0;
            r_a_is_big       <= '0;
        end else if (w_s2_adv) begin
            r_out_valid      <= 1'b1;
            r_exponent_diff  <= w_diff;
            r_exponent_big   <= w_exp_big;
            r_mantissa_big   <= w_man_big;
            r_mantissa_small <= w_man_small;
            r_a_is_big       <= w_a_big;
        end else if (out_ready) begin
            r_out_valid      <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid & ~rst;
    assign exponent_diff  = r_exponent_diff;
    assign exponent_big   = r_exponent_big;
    assign mantissa_big   = r_mantissa_big;
    assign mantissa_small = r_mantissa_small;
    assign a_is_big       = r_a_is_big;

endmodule

// File: tb/tb_fp_adder_multi_compare_stage.sv
// tb_fp_adder_multi_compare_stage
// Self-checking bench: directed beats with hand-computed results, then random
// traffic and back-pressure checked against a queue-based reference model.
// Works with or without FP_CMP_DIFF_SAT_EN defined.
module tb_fp_adder_multi_compare_stage;

    localparam int L  = 2;
    localparam int EW = 8;
    localparam int MW = 24;
    localparam int DW = EW + 1;

`ifdef FP_CMP_DIFF_SAT_EN
    localparam logic [DW-1:0] EXT_DIFF = 9'd24;
`else
    localparam logic [DW-1:0] EXT_DIFF = 9'd255;
`endif

    typedef struct {
        logic          bias;
        logic [L*EW-1:0] ea, eba, eb;
        logic [L*MW-1:0] ma, mba, mb;
    } in_t;

    typedef struct {
        logic [L*DW-1:0] diff;
        logic [L*EW-1:0] ebig;
        logic [L*MW-1:0] mbig, msmall;
        logic [L-1:0]    abig;
        int              t;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            bias_mode;
    logic [L*EW-1:0] exponent_acc, exponent_bias, exponent_b;
    logic [L*MW-1:0] mantissa_acc, mantissa_bias, mantissa_b;
    logic            out_valid;
    logic            out_ready;
    logic [L*DW-1:0] exponent_diff;
    logic [L*EW-1:0] exponent_big;
    logic [L*MW-1:0] mantissa_big, mantissa_small;
    logic [L-1:0]    a_is_big;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    fp_adder_multi_compare_stage #(
        .LANES(L), .EXPONENT_WIDTH(EW), .MANTISA_WIDTH(MW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .bias_mode(bias_mode),
        .exponent_acc(exponent_acc), .exponent_bias(exponent_bias), .exponent_b(exponent_b),
        .mantissa_acc(mantissa_acc), .mantissa_bias(mantissa_bias), .mantissa_b(mantissa_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .exponent_diff(exponent_diff), .exponent_big(exponent_big),
        .mantissa_big(mantissa_big), .mantissa_small(mantissa_small),
        .a_is_big(a_is_big)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: pick A, compare signed exponents, larger one is big (tie -> B).
    function automatic exp_t model(input in_t x, input int t);
        exp_t r;
        r = '{default: '0};
        r.t = t;
        for (int i = 0; i < L; i++) begin
            logic signed [EW-1:0] sa, sb;
            logic [MW-1:0] man_a, man_b;
            int a, b, d;
            sa    = x.bias ? x.eba[i*EW +: EW] : x.ea[i*EW +: EW];
            sb    = x.eb[i*EW +: EW];
            man_a = x.bias ? x.mba[i*MW +: MW] : x.ma[i*MW +: MW];
            man_b = x.mb[i*MW +: MW];
            a = sa;
            b = sb;
            d = (b > a) ? b - a : a - b;
`ifdef FP_CMP_DIFF_SAT_EN
            if (d > MW) d = MW;
`endif
            r.diff[i*DW +: DW] = DW'(d);
            if (b < a) begin
                r.ebig[i*EW +: EW]   = sa;
                r.mbig[i*MW +: MW]   = man_a;
                r.msmall[i*MW +: MW] = man_b;
                r.abig[i]            = 1'b1;
            end else begin
                r.ebig[i*EW +: EW]   = sb;
                r.mbig[i*MW +: MW]   = man_b;
                r.msmall[i*MW +: MW] = man_a;
            end
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] rexp();
        case ($urandom_range(0, 3))
            0:       return EW'(int'($urandom_range(0, 6)) - 3);
            1:       return $urandom_range(0, 1) ? 8'h7F : 8'h80;
            default: return EW'($urandom());
        endcase
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.bias = 1'($urandom_range(0, 1));
        for (int i = 0; i < L; i++) begin
            x.ea[i*EW +: EW]  = rexp();
            x.eba[i*EW +: EW] = rexp();
            x.eb[i*EW +: EW]  = rexp();
            x.ma[i*MW +: MW]  = MW'($urandom());
            x.mba[i*MW +: MW] = MW'($urandom());
            x.mb[i*MW +: MW]  = MW'($urandom());
        end
        return x;
    endfunction

    task automatic apply(input in_t x);
        bias_mode     = x.bias;
        exponent_acc  = x.ea;
        exponent_bias = x.eba;
        exponent_b    = x.eb;
        mantissa_acc  = x.ma;
        mantissa_bias = x.mba;
        mantissa_b    = x.mb;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input in_t x);
        int w = 0;
        apply(x);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Compare process: every cycle checks handshake state and, while
    // out_valid, the presented result against the oldest pending beat.
    always @(negedge clk) begin
        in_t s;
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            check("in_ready", in_ready, (q.size() < 2) || out_ready);
            check("out_valid", out_valid, (q.size() > 0) && (q[0].t <= cyc - 2));
            if (out_valid && q.size() > 0) begin
                check("exponent_diff", exponent_diff, q[0].diff);
                check("exponent_big", exponent_big, q[0].ebig);
                check("mantissa_big", mantissa_big, q[0].mbig);
                check("mantissa_small", mantissa_small, q[0].msmall);
                check("a_is_big", a_is_big, q[0].abig);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                s.bias = bias_mode;
                s.ea = exponent_acc; s.eba = exponent_bias; s.eb = exponent_b;
                s.ma = mantissa_acc; s.mba = mantissa_bias; s.mb = mantissa_b;
                q.push_back(model(s, cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  xb, xbias, xext;
        exp_t m;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        apply(rand_in());
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_diff", exponent_diff, '0);
        check("reset_big", mantissa_big, '0);
        check("reset_a_is_big", a_is_big, '0);

        // Basic compare: lane0 A bigger, lane1 tie -> B big.
        xb = '{default: '0};
        xb.ea = {8'hFC, 8'd5};         xb.eb = {8'hFC, 8'd3};
        xb.ma = {24'h100000, 24'h400000}; xb.mb = {24'h300000, 24'h200000};
        m = model(xb, 0);
        check("model_basic_diff", m.diff, {9'd0, 9'd2});
        check("model_basic_abig", m.abig, 2'b01);

        @(posedge clk);
        #1 out_ready = 1'b1;
        send(xb);
        @(negedge clk);
        check("basic_latency_1", out_valid, 1'b0);
        @(negedge clk);
        check("basic_out_valid", out_valid, 1'b1);
        check("basic_diff", exponent_diff, {9'd0, 9'd2});
        check("basic_ebig", exponent_big, {8'hFC, 8'd5});
        check("basic_mbig", mantissa_big, {24'h300000, 24'h400000});
        check("basic_msmall", mantissa_small, {24'h100000, 24'h200000});
        check("basic_abig", a_is_big, 2'b01);

        // Bias select, then the same data with bias_mode toggled back-to-back.
        xbias = '{default: '0};
        xbias.bias = 1'b1;
        xbias.eba = {8'd0, 8'd10}; xbias.ea = {8'd0, 8'd20}; xbias.eb = {8'd0, 8'd7};
        xbias.mba = {24'h0, 24'h123456}; xbias.ma = {24'h0, 24'h654321};
        xbias.mb = {24'h0, 24'h0ABCDE};
        @(posedge clk);
        #1;
        send(xbias);
        xbias.bias = 1'b0;
        send(xbias);
        @(negedge clk);
        check("bias_diff", exponent_diff, {9'd0, 9'd3});
        check("bias_ebig", exponent_big, {8'd0, 8'd10});
        check("bias_mbig", mantissa_big, {24'h0, 24'h123456});
        check("bias_msmall", mantissa_small, {24'h0, 24'h0ABCDE});
        @(negedge clk);
        check("acc_diff", exponent_diff, {9'd0, 9'd13});
        check("acc_ebig", exponent_big, {8'd0, 8'd20});
        check("acc_mbig", mantissa_big, {24'h0, 24'h654321});
        check("acc_abig", a_is_big, 2'b01);

        // Extreme exponent range in both directions.
        xext = '{default: '0};
        xext.ea = {8'd127, 8'h80}; xext.eb = {8'h80, 8'd127};
        xext.ma = {24'hAAAAAA, 24'h111111}; xext.mb = {24'h555555, 24'h222222};
        m = model(xext, 0);
        check("model_ext_diff", m.diff, {EXT_DIFF, EXT_DIFF});
        @(posedge clk);
        #1;
        send(xext);
        @(negedge clk);
        @(negedge clk);
        check("ext_diff", exponent_diff, {EXT_DIFF, EXT_DIFF});
        check("ext_ebig", exponent_big, {8'd127, 8'd127});
        check("ext_mbig", mantissa_big, {24'hAAAAAA, 24'h222222});
        check("ext_msmall", mantissa_small, {24'h555555, 24'h111111});
        check("ext_abig", a_is_big, 2'b10);

        // Back-pressure: 4 beats against a stalled output, then release.
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(rand_in());
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_out_valid", out_valid, 1'b1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_drained", q.size(), 0);

        // Random traffic with random back-pressure.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            apply(rand_in());
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rand_drained", q.size(), 0);

        // Reset with both stages full.
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b1; apply(rand_in());
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_full", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_diff", exponent_diff, '0);
        check("rst_mid_ebig", exponent_big, '0);
        check("rst_mid_msmall", mantissa_small, '0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(xb);
        @(negedge clk);
        check("post_rst_latency_1", out_valid, 1'b0);
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b1);
        check("post_rst_diff", exponent_diff, {9'd0, 9'd2});

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
